// File: rtl/elevator_scheduler.sv
// SCAN request scheduler that steps the 4-floor elevator core one floor at a time.
// Optional idle parking to floor 0 is enabled by defining ELEV_SCHED_PARK_EN.
module elevator_scheduler #(
   parameter int unsigned FLOOR_W      = 2,
   parameter int unsigned DWELL_CYCLES = 3
`ifdef ELEV_SCHED_PARK_EN
   ,
   parameter int unsigned PARK_CYCLES  = 8
`endif
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [(1<<FLOOR_W)-1:0]     req,
   input  logic                        emergency,
   input  logic                        z1,
   input  logic                        z0,
   output logic                        x1,
   output logic                        x0,
   output logic                        door_open,
   output logic                        dir_up,
   output logic [(1<<FLOOR_W)-1:0]     pending,
   output logic                        busy
);

   localparam int unsigned NF   = 1 << FLOOR_W;
   localparam int unsigned DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DW_W-1:0]    DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MOVE,
      S_SETTLE,
      S_DWELL,
      S_EMERG
   } state_t;

   state_t              state;
   logic [1:0]          x_r;
   logic [DW_W-1:0]     dwell_cnt;
   logic [FLOOR_W-1:0]  f;
   logic                above_c;
   logic                below_c;
   logic                here_c;
   logic                go_c;
   logic                go_up_c;
   logic                step_bad_c;
   logic                move_bad_c;
   logic                to_dwell_c;
   logic [NF-1:0]       clr_c;

`ifdef ELEV_SCHED_PARK_EN
   localparam int unsigned PK_W = $clog2(PARK_CYCLES + 1);
   logic [PK_W-1:0]     park_cnt;
   logic                parking;
   logic                park_idle_c;
   logic                park_fire_c;
   logic                park_walk_c;

   assign park_idle_c = (pending == '0) && (req == '0) && (f != '0);
   assign park_fire_c = (state == S_IDLE) && park_idle_c && (park_cnt == PK_W'(PARK_CYCLES));
   assign park_walk_c = (state == S_SETTLE) && parking && (pending == '0) && (f != '0);
`endif

   assign f = FLOOR_W'({z1, z0});

   // Hold is applied combinationally so an emergency stops motion in the same cycle.
   assign x1 = x_r[1] & ~emergency;
   assign x0 = x_r[0] & ~emergency;

   // Outstanding calls strictly above / below the current floor.
   always_comb begin
      above_c = 1'b0;
      below_c = 1'b0;
      for (int unsigned i = 0; i < NF; i++) begin
         if (FLOOR_W'(i) > f) above_c = above_c | pending[i];
         if (FLOOR_W'(i) < f) below_c = below_c | pending[i];
      end
   end

   assign here_c = pending[f];

   // Step decision for IDLE and SETTLE; SETTLE keeps the current sweep direction.
   always_comb begin
      go_c    = 1'b0;
      go_up_c = dir_up;
      case (state)
         S_IDLE: begin
            go_c    = above_c | below_c;
            go_up_c = above_c && (dir_up || !below_c);
`ifdef ELEV_SCHED_PARK_EN
            if (park_fire_c) begin
               go_c    = 1'b1;
               go_up_c = 1'b0;
            end
`endif
         end
         S_SETTLE: begin
            go_c = dir_up ? above_c : below_c;
`ifdef ELEV_SCHED_PARK_EN
            if (park_walk_c) begin
               go_c    = 1'b1;
               go_up_c = 1'b0;
            end
`endif
         end
         default: ;
      endcase
   end

   assign step_bad_c = go_up_c ? (f == TOP_FLOOR) : (f == '0);
   assign move_bad_c = ((x_r == 2'b11) && (f == TOP_FLOOR)) || ((x_r == 2'b01) && (f == '0));

   // The current-floor call is consumed whenever the next state is DWELL.
   assign to_dwell_c = !emergency &&
                       ((((state == S_IDLE) || (state == S_SETTLE)) && here_c) ||
                        ((state == S_DWELL) && (req[f] || (dwell_cnt != '0))));
   assign clr_c = to_dwell_c ? (NF'(1) << f) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pending   <= '0;
         x_r       <= 2'b00;
         door_open <= 1'b0;
         dir_up    <= 1'b1;
         busy      <= 1'b0;
         dwell_cnt <= '0;
`ifdef ELEV_SCHED_PARK_EN
         park_cnt  <= '0;
         parking   <= 1'b0;
`endif
      end else begin
         pending <= (pending | req) & ~clr_c;
         if (emergency) begin
            state     <= S_EMERG;
            busy      <= 1'b1;
            x_r       <= 2'b00;
            door_open <= 1'b0;
            dwell_cnt <= '0;
`ifdef ELEV_SCHED_PARK_EN
            parking   <= 1'b0;
`endif
         end else begin
            case (state)
               S_IDLE, S_SETTLE: begin
                  x_r       <= 2'b00;
                  door_open <= 1'b0;
`ifdef ELEV_SCHED_PARK_EN
                  parking   <= park_fire_c | park_walk_c;
`endif
                  if (here_c) begin
                     state     <= S_DWELL;
                     busy      <= 1'b1;
                     door_open <= 1'b1;
                     dwell_cnt <= DWELL_LOAD;
                  end else if (go_c && !step_bad_c) begin
                     state  <= S_MOVE;
                     busy   <= 1'b1;
                     dir_up <= go_up_c;
                     x_r    <= go_up_c ? 2'b11 : 2'b01;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
               S_MOVE: begin
                  x_r   <= 2'b00;
                  state <= move_bad_c ? S_IDLE : S_SETTLE;
                  busy  <= !move_bad_c;
               end
               S_DWELL: begin
                  x_r <= 2'b00;
                  if (req[f]) begin
                     dwell_cnt <= DWELL_LOAD;
                  end else if (dwell_cnt == '0) begin
                     state     <= S_IDLE;
                     busy      <= 1'b0;
                     door_open <= 1'b0;
                  end else begin
                     dwell_cnt <= dwell_cnt - DW_W'(1);
                  end
               end
               default: begin
                  state     <= S_IDLE;
                  busy      <= 1'b0;
                  x_r       <= 2'b00;
                  door_open <= 1'b0;
               end
            endcase
         end
`ifdef ELEV_SCHED_PARK_EN
         // Park timer only runs while sitting idle off floor 0 with nothing to do.
         if (!emergency && (state == S_IDLE) && park_idle_c && !park_fire_c)
            park_cnt <= park_cnt + PK_W'(1);
         else
            park_cnt <= '0;
`endif
      end
   end

   a_step_legal: assert property (@(posedge clk) disable iff (!rst_n)
      !(({x1, x0} == 2'b11) && (f == TOP_FLOOR)) && !(({x1, x0} == 2'b01) && (f == '0)));

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with a behavioural one-step elevator core.
// Parking checks are compiled when ELEV_SCHED_PARK_EN is defined.
module tb_elevator_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       emergency;
   logic [1:0] fl;
   logic       x1, x0, door_open, dir_up, busy;
   logic [3:0] pending;
   int         n_cmp = 0;
   int         n_bad = 0;

   elevator_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .emergency (emergency),
      .z1        (fl[1]),
      .z0        (fl[0]),
      .x1        (x1),
      .x0        (x0),
      .door_open (door_open),
      .dir_up    (dir_up),
      .pending   (pending),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Core model: moves one floor per step command, saturating at the shaft ends.
   always @(posedge clk) begin
      if ({x1, x0} == 2'b11 && fl != 2'd3) fl <= fl + 2'd1;
      else if ({x1, x0} == 2'b01 && fl != 2'd0) fl <= fl - 2'd1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] floor);
      rst_n     = 1'b0;
      req       = '0;
      emergency = 1'b0;
      fl        = floor;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; req = '0; emergency = 1'b0; fl = 2'd0;
      #2 rst_n = 1'b0;
      tick();
      n_cmp++;
      if ({x1, x0, door_open, busy, pending} !== 8'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: x/door/busy/pending=%b want 00000000", {x1, x0, door_open, busy, pending});
      end
      n_cmp++;
      if (dir_up !== 1'b1) begin
         n_bad++; $display("FAIL reset_dir_up: got %b want 1", dir_up);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_call();
      logic [2:0] seq [];
      do_reset(2'd0);
      req = 4'b0100; tick(); req = '0;
      n_cmp++;
      if (pending !== 4'b0100) begin
         n_bad++; $display("FAIL single_latch: pending=%b want 0100", pending);
      end
      seq = '{3'b110, 3'b000, 3'b110, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000};
      foreach (seq[i]) begin
         tick();
         n_cmp++;
         if ({x1, x0, door_open} !== seq[i]) begin
            n_bad++; $display("FAIL single_seq[%0d]: x/door=%b want %b", i, {x1, x0, door_open}, seq[i]);
         end
         if (i == 4) begin
            n_cmp++;
            if (pending !== 4'b0000) begin
               n_bad++; $display("FAIL single_clr: pending=%b want 0000", pending);
            end
         end
      end
      n_cmp++;
      if ({busy, fl} !== 3'b010) begin
         n_bad++; $display("FAIL single_end: busy/floor=%b want 010", {busy, fl});
      end
   endtask

   task automatic test_scan_up_first();
      logic [2:0] seq [];
      do_reset(2'd1);
      req = 4'b1001; tick(); req = '0;
      seq = '{3'b110, 3'b000, 3'b110, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000,
              3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000};
      foreach (seq[i]) begin
         tick();
         n_cmp++;
         if ({x1, x0, door_open} !== seq[i]) begin
            n_bad++; $display("FAIL scan_up_seq[%0d]: x/door=%b want %b", i, {x1, x0, door_open}, seq[i]);
         end
         if (i == 4) begin
            n_cmp++;
            if (pending !== 4'b0001) begin
               n_bad++; $display("FAIL scan_up_mid: pending=%b want 0001", pending);
            end
         end
      end
      n_cmp++;
      if ({busy, dir_up, fl, pending} !== 8'b00000000) begin
         n_bad++; $display("FAIL scan_up_end: busy/dir/floor/pending=%b want 00000000", {busy, dir_up, fl, pending});
      end
   endtask

   task automatic test_dwell_extend();
      logic [2:0] seq [];
      do_reset(2'd3);
      req = 4'b1000; tick(); req = '0;
      tick();
      n_cmp++;
      if ({x1, x0, door_open, pending} !== 7'b0010000) begin
         n_bad++; $display("FAIL dwell_entry: x/door/pending=%b want 0010000", {x1, x0, door_open, pending});
      end
      tick();
      req = 4'b1000; tick(); req = '0;
      n_cmp++;
      if ({x1, x0, door_open, pending} !== 7'b0010000) begin
         n_bad++; $display("FAIL dwell_reload: x/door/pending=%b want 0010000", {x1, x0, door_open, pending});
      end
      seq = '{3'b001, 3'b001, 3'b000, 3'b000};
      foreach (seq[i]) begin
         tick();
         n_cmp++;
         if ({x1, x0, door_open} !== seq[i]) begin
            n_bad++; $display("FAIL dwell_ext_seq[%0d]: x/door=%b want %b", i, {x1, x0, door_open}, seq[i]);
         end
      end
      n_cmp++;
      if ({busy, fl} !== 3'b011) begin
         n_bad++; $display("FAIL dwell_end: busy/floor=%b want 011", {busy, fl});
      end
   endtask

   task automatic test_emergency();
      logic [2:0] seq [];
      do_reset(2'd1);
      req = 4'b1000; tick(); req = '0;
      tick();
      n_cmp++;
      if ({x1, x0} !== 2'b11) begin
         n_bad++; $display("FAIL emerg_pre: x=%b want 11", {x1, x0});
      end
      emergency = 1'b1; req = 4'b0001;
      #1;
      n_cmp++;
      if ({x1, x0} !== 2'b00) begin
         n_bad++; $display("FAIL emerg_same_cycle: x=%b want 00", {x1, x0});
      end
      tick(); req = '0;
      n_cmp++;
      if ({x1, x0, door_open, busy, dir_up, fl, pending} !== 11'b00011011001) begin
         n_bad++; $display("FAIL emerg_hold: x/door/busy/dir/floor/pending=%b want 00011011001",
                           {x1, x0, door_open, busy, dir_up, fl, pending});
      end
      tick();
      n_cmp++;
      if ({x1, x0, fl} !== 4'b0001) begin
         n_bad++; $display("FAIL emerg_still: x/floor=%b want 0001", {x1, x0, fl});
      end
      emergency = 1'b0;
      seq = '{3'b000, 3'b110, 3'b000, 3'b110, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000,
              3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000};
      foreach (seq[i]) begin
         tick();
         n_cmp++;
         if ({x1, x0, door_open} !== seq[i]) begin
            n_bad++; $display("FAIL emerg_resume[%0d]: x/door=%b want %b", i, {x1, x0, door_open}, seq[i]);
         end
      end
      n_cmp++;
      if ({busy, fl, pending} !== 7'b0000000) begin
         n_bad++; $display("FAIL emerg_end: busy/floor/pending=%b want 0000000", {busy, fl, pending});
      end
   endtask

   task automatic test_scan_down_first();
      logic [2:0] seq [];
      do_reset(2'd3);
      req = 4'b0100; tick(); req = '0;
      seq = '{3'b010, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000};
      foreach (seq[i]) begin
         tick();
         n_cmp++;
         if ({x1, x0, door_open} !== seq[i]) begin
            n_bad++; $display("FAIL scan_dn_pre[%0d]: x/door=%b want %b", i, {x1, x0, door_open}, seq[i]);
         end
      end
      req = 4'b1001; tick(); req = '0;
      seq = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000,
              3'b110, 3'b000, 3'b110, 3'b000, 3'b110, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000};
      foreach (seq[i]) begin
         tick();
         n_cmp++;
         if ({x1, x0, door_open} !== seq[i]) begin
            n_bad++; $display("FAIL scan_dn_seq[%0d]: x/door=%b want %b", i, {x1, x0, door_open}, seq[i]);
         end
         if (i == 0) begin
            n_cmp++;
            if (dir_up !== 1'b0) begin
               n_bad++; $display("FAIL scan_dn_dir: dir_up=%b want 0", dir_up);
            end
         end
      end
      n_cmp++;
      if ({busy, dir_up, fl, pending} !== 8'b01110000) begin
         n_bad++; $display("FAIL scan_dn_end: busy/dir/floor/pending=%b want 01110000", {busy, dir_up, fl, pending});
      end
   endtask

   task automatic test_reset_mid_trip();
      do_reset(2'd0);
      req = 4'b0100; tick(); req = '0;
      tick();
      tick();
      n_cmp++;
      if ({busy, x1, x0, fl, pending} !== 9'b100010100) begin
         n_bad++; $display("FAIL midreset_pre: busy/x/floor/pending=%b want 100010100", {busy, x1, x0, fl, pending});
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({x1, x0, door_open, busy, dir_up, pending} !== 9'b000010000) begin
         n_bad++; $display("FAIL midreset_async: x/door/busy/dir/pending=%b want 000010000",
                           {x1, x0, door_open, busy, dir_up, pending});
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if ({x1, x0, door_open, busy} !== 4'b0000) begin
            n_bad++; $display("FAIL midreset_idle[%0d]: x/door/busy=%b want 0000", i, {x1, x0, door_open, busy});
         end
      end
      n_cmp++;
      if (fl !== 2'd1) begin
         n_bad++; $display("FAIL midreset_floor: floor=%0d want 1", fl);
      end
   endtask

`ifdef ELEV_SCHED_PARK_EN
   task automatic test_park();
      logic [2:0] seq [];
      do_reset(2'd2);
      seq = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
              3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
      foreach (seq[i]) begin
         tick();
         n_cmp++;
         if ({x1, x0, door_open} !== seq[i]) begin
            n_bad++; $display("FAIL park_seq[%0d]: x/door=%b want %b", i, {x1, x0, door_open}, seq[i]);
         end
      end
      n_cmp++;
      if ({busy, fl} !== 3'b000) begin
         n_bad++; $display("FAIL park_end: busy/floor=%b want 000", {busy, fl});
      end
   endtask

   task automatic test_park_abort();
      logic [2:0] seq [];
      do_reset(2'd3);
      for (int i = 0; i < 8; i++) tick();
      tick();
      n_cmp++;
      if ({x1, x0} !== 2'b01) begin
         n_bad++; $display("FAIL park_abort_start: x=%b want 01", {x1, x0});
      end
      req = 4'b1000; tick(); req = '0;
      seq = '{3'b000, 3'b110, 3'b000, 3'b001};
      foreach (seq[i]) begin
         tick();
         n_cmp++;
         if ({x1, x0, door_open} !== seq[i]) begin
            n_bad++; $display("FAIL park_abort_seq[%0d]: x/door=%b want %b", i, {x1, x0, door_open}, seq[i]);
         end
      end
      n_cmp++;
      if (fl !== 2'd3) begin
         n_bad++; $display("FAIL park_abort_floor: floor=%0d want 3", fl);
      end
   endtask
`else
   task automatic test_no_park();
      do_reset(2'd2);
      for (int i = 0; i < 12; i++) begin
         tick();
         n_cmp++;
         if ({x1, x0, door_open, busy} !== 4'b0000) begin
            n_bad++; $display("FAIL no_park[%0d]: x/door/busy=%b want 0000", i, {x1, x0, door_open, busy});
         end
      end
      n_cmp++;
      if (fl !== 2'd2) begin
         n_bad++; $display("FAIL no_park_floor: floor=%0d want 2", fl);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_call();
      test_scan_up_first();
      test_dwell_extend();
      test_emergency();
      test_scan_down_first();
      test_reset_mid_trip();
`ifdef ELEV_SCHED_PARK_EN
      test_park();
      test_park_abort();
`else
      test_no_park();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
